clkdiv_prog: RTL and testbench

//   Runtime-programmable integer clock divider. Divides clk_i by any D in 2..2**CNT_W-1.

---
 rtl/clkdiv_prog.sv | 137 +++++++++++++
 tb/tb_clkdiv_prog.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/clkdiv_prog.sv
// Runtime-programmable integer clock divider with a tick strobe and a glitch-free divided clock.
// Optional build macro CLKDIV_ODD50_EN gives odd divisors an exact 50% duty via a negedge flop.
module clkdiv_prog #(
  parameter int CNT_W   = 8,
  parameter int DIV_RST = 2
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] div_i,
  input  logic             div_load_i,
  output logic             pend_o,
  output logic             div_ack_o,
  output logic [CNT_W-1:0] div_o,
  output logic             tick_o,
  output logic             dclk_o
);

  localparam logic [CNT_W-1:0] C_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_TWO  = CNT_W'(2);
  localparam logic [CNT_W-1:0] C_RST  = CNT_W'(DIV_RST);
  localparam logic [CNT_W:0]   C_ONE_W = (CNT_W+1)'(1);

  function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] d);
    if (d < C_TWO) begin
      return C_TWO;
    end else begin
      return d;
    end
  endfunction

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_dact;
  logic [CNT_W-1:0] r_pend_val;
  logic             r_pend;
  logic             r_ack;
  logic             r_tick;
  logic             r_dclk_pos;

  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_wrap;
  logic             w_apply;
  logic [CNT_W:0]   w_half;
  logic             w_tick_nxt;
  logic             w_dclk_nxt;

  // Next count, wrap detection and the registered-output terms derived from it.
  always_comb begin
    w_cnt_nxt  = C_ZERO;
    w_wrap     = 1'b0;
    w_apply    = 1'b0;
    w_half     = (CNT_W+1)'(0);
    w_tick_nxt = 1'b0;
    w_dclk_nxt = 1'b0;
    if (en_i) begin
      // >= rather than == so a corrupted count still recovers within one period
      if (r_cnt >= (r_dact - C_ONE)) begin
        w_cnt_nxt = C_ZERO;
        w_wrap    = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + C_ONE;
        w_wrap    = 1'b0;
      end
    end else begin
      w_cnt_nxt = C_ZERO;
      w_wrap    = 1'b0;
    end
    w_apply    = r_pend & (~en_i | w_wrap);
    w_half     = ({1'b0, r_dact} + C_ONE_W) >> 1;
    w_tick_nxt = en_i & (w_cnt_nxt == C_ZERO);
    w_dclk_nxt = en_i & ({1'b0, w_cnt_nxt} < w_half);
  end

  // Counter and divided-clock output registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_cnt      <= C_ZERO;
      r_tick     <= 1'b0;
      r_dclk_pos <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_tick     <= w_tick_nxt;
      r_dclk_pos <= w_dclk_nxt;
    end
  end

  // Divisor capture and boundary-aligned apply; a load in the apply cycle stays pending.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_dact     <= C_RST;
      r_pend_val <= C_RST;
      r_pend     <= 1'b0;
      r_ack      <= 1'b0;
    end else begin
      r_ack <= w_apply;
      if (w_apply) begin
        r_dact <= r_pend_val;
      end else begin
        r_dact <= r_dact;
      end
      if (div_load_i) begin
        r_pend_val <= clamp_div(div_i);
        r_pend     <= 1'b1;
      end else if (w_apply) begin
        r_pend_val <= r_pend_val;
        r_pend     <= 1'b0;
      end else begin
        r_pend_val <= r_pend_val;
        r_pend     <= r_pend;
      end
    end
  end

`ifdef CLKDIV_ODD50_EN
  logic r_dclk_neg;

  // Half-cycle delayed copy trims the extra high half-cycle of odd divisors.
  always_ff @(negedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_dclk_neg <= 1'b0;
    end else begin
      r_dclk_neg <= r_dclk_pos;
    end
  end

  assign dclk_o = r_dact[0] ? (r_dclk_pos & r_dclk_neg) : r_dclk_pos;
`else
  assign dclk_o = r_dclk_pos;
`endif

  assign pend_o    = r_pend;
  assign div_ack_o = r_ack;
  assign div_o     = r_dact;
  assign tick_o    = r_tick;

endmodule

// File: tb/tb_clkdiv_prog.sv
// Directed self-checking bench for clkdiv_prog (CNT_W=8, DIV_RST=2).
module tb_clkdiv_prog;

  logic       clk_i;
  logic       rstn_i;
  logic       en_i;
  logic [7:0] div_i;
  logic       div_load_i;
  logic       pend_o;
  logic       div_ack_o;
  logic [7:0] div_o;
  logic       tick_o;
  logic       dclk_o;

  int checks_cnt = 0;
  int errors_cnt = 0;
  int n_ack      = 0;
  int n, per, hi, ack0;

  clkdiv_prog #(.CNT_W(8), .DIV_RST(2)) dut (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .en_i       (en_i),
    .div_i      (div_i),
    .div_load_i (div_load_i),
    .pend_o     (pend_o),
    .div_ack_o  (div_ack_o),
    .div_o      (div_o),
    .tick_o     (tick_o),
    .dclk_o     (dclk_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input int got, input int exp);
    checks_cnt++;
    if (got != exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge and sample just after it; counts ack pulses seen.
  task automatic step();
    @(posedge clk_i);
    #1;
    if (div_ack_o) n_ack++;
  endtask

  // Edges until tick_o is seen (bounded); -1 on timeout.
  task automatic wait_tick(output int edges);
    edges = 0;
    do begin
      step();
      edges++;
    end while (!tick_o && edges < 600);
    if (!tick_o) edges = -1;
  endtask

  // Called at a tick sample: period length and dclk high samples until the next tick.
  task automatic meas_period(output int p, output int h);
    p = 0;
    h = 0;
    do begin
      if (dclk_o) h++;
      step();
      p++;
    end while (!tick_o && p < 600);
    if (!tick_o) p = -1;
  endtask

  task automatic load(input logic [7:0] d);
    div_i      = d;
    div_load_i = 1'b1;
    step();
    div_load_i = 1'b0;
  endtask

  initial begin
    rstn_i     = 1'b0;
    en_i       = 1'b1;
    div_i      = 8'd0;
    div_load_i = 1'b0;
    #12;
    chk("rst_tick", tick_o, 0);
    chk("rst_dclk", dclk_o, 0);
    chk("rst_div", div_o, 2);
    chk("rst_pend", pend_o, 0);
    chk("rst_ack", div_ack_o, 0);

    // 1: default divisor 2
    @(negedge clk_i);
    rstn_i = 1'b1;
    wait_tick(n);
    chk("t1_first_tick", n, 2);
    chk("t1_dclk_at_tick", dclk_o, 1);
    meas_period(per, hi);
    chk("t1_period", per, 2);
    chk("t1_high", hi, 1);

    // 2: load 5 mid-period
    ack0 = n_ack;
    load(8'd5);
    chk("t2_pend", pend_o, 1);
    chk("t2_div_old", div_o, 2);
    step();
    chk("t2_wrap_tick", tick_o, 1);
    chk("t2_ack", div_ack_o, 1);
    chk("t2_div_new", div_o, 5);
    chk("t2_pend_clr", pend_o, 0);
    meas_period(per, hi);
    chk("t2_period", per, 5);
    chk("t2_high", hi, 3);
    chk("t2_ack_count", n_ack - ack0, 1);

    // 3: clamps and maximum divisor
    load(8'd0);
    wait_tick(n);
    chk("t3_wait0", n, 4);
    chk("t3_clamp0_div", div_o, 2);
    chk("t3_clamp0_ack", div_ack_o, 1);
    load(8'd1);
    step();
    chk("t3_clamp1_div", div_o, 2);
    chk("t3_clamp1_ack", div_ack_o, 1);
    meas_period(per, hi);
    chk("t3_clamp_period", per, 2);
    load(8'd255);
    wait_tick(n);
    chk("t3_div255", div_o, 255);
    meas_period(per, hi);
    chk("t3_period255", per, 255);
    chk("t3_high255", hi, 128);

    // 4: back-to-back loads, then load exactly on a wrap
    ack0 = n_ack;
    load(8'd7);
    load(8'd9);
    wait_tick(n);
    chk("t4_div9", div_o, 9);
    meas_period(per, hi);
    chk("t4_period9", per, 9);
    chk("t4_single_ack", n_ack - ack0, 1);
    load(8'd3);
    for (int i = 0; i < 7; i++) step();
    div_i      = 8'd4;
    div_load_i = 1'b1;
    step();
    div_load_i = 1'b0;
    chk("t4_wrap_tick", tick_o, 1);
    chk("t4_wrap_ack", div_ack_o, 1);
    chk("t4_wrap_div", div_o, 3);
    chk("t4_wrap_pend", pend_o, 1);
    meas_period(per, hi);
    chk("t4_period3", per, 3);
    chk("t4_high3", hi, 2);
    chk("t4_next_ack", div_ack_o, 1);
    chk("t4_next_div", div_o, 4);
    chk("t4_next_pend", pend_o, 0);

    // 5: disable with a pending load, then re-enable
    load(8'd6);
    en_i = 1'b0;
    step();
    chk("t5_ack", div_ack_o, 1);
    chk("t5_div", div_o, 6);
    chk("t5_pend", pend_o, 0);
    chk("t5_tick", tick_o, 0);
    chk("t5_dclk", dclk_o, 0);
    step();
    chk("t5_ack_once", div_ack_o, 0);
    en_i = 1'b1;
    wait_tick(n);
    chk("t5_reenable", n, 6);

    // 6: asynchronous reset mid-period with a pending load
    load(8'd10);
    chk("t6_pend_before", pend_o, 1);
    chk("t6_dclk_before", dclk_o, 1);
    #2;
    rstn_i = 1'b0;
    #1;
    chk("t6_pend", pend_o, 0);
    chk("t6_div", div_o, 2);
    chk("t6_dclk", dclk_o, 0);
    chk("t6_tick", tick_o, 0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    wait_tick(n);
    chk("t6_first_tick", n, 2);
    chk("t6_div_after", div_o, 2);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
